// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// Optional ovf field exists only when OVERFLOW_DETECT_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef OVERFLOW_DETECT_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder reusing one full-adder cell WIDTH times.
// Define OVERFLOW_DETECT_EN to add the signed-overflow flag (ovf).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    serial_adder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] a_sh_s;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] b_sh_s;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_s;
    logic             carry_r;
    logic             carry_s;
    logic             cout_r;
    logic             cout_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             in_ready_r;
    logic             in_ready_s;
    logic             out_valid_r;
    logic             out_valid_s;
    logic             bit_sum_s;
    logic             bit_carry_s;
    logic             last_bit_s;
`ifdef OVERFLOW_DETECT_EN
    logic             ovf_r;
    logic             ovf_s;
`endif

    // Shared full-adder cell fed by the LSBs of the operand shift registers
    always_comb begin
        bit_sum_s   = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
        bit_carry_s = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);
        last_bit_s  = (cnt_r == LAST_CNT);
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_s = state_r;
        a_sh_s  = a_sh_r;
        b_sh_s  = b_sh_r;
        sum_s   = sum_r;
        carry_s = carry_r;
        cout_s  = cout_r;
        cnt_s   = cnt_r;
`ifdef OVERFLOW_DETECT_EN
        ovf_s   = ovf_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_s  = bus.a;
                    b_sh_s  = bus.b;
                    carry_s = bus.cin;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Sum bits enter at the MSB so bit 0 lands in the LSB after WIDTH shifts
                sum_s   = {bit_sum_s, sum_r[WIDTH-1:1]};
                a_sh_s  = {1'b0, a_sh_r[WIDTH-1:1]};
                b_sh_s  = {1'b0, b_sh_r[WIDTH-1:1]};
                carry_s = bit_carry_s;
                cnt_s   = cnt_r + CNT_ONE;
                if (last_bit_s) begin
                    cout_s  = bit_carry_s;
`ifdef OVERFLOW_DETECT_EN
                    ovf_s   = carry_r ^ bit_carry_s;
`endif
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        in_ready_s  = (state_s == ST_IDLE);
        out_valid_s = (state_s == ST_DONE);
    end

    // State and datapath registers; reset wins over any in-flight addition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_sh_r      <= {WIDTH{1'b0}};
            b_sh_r      <= {WIDTH{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            a_sh_r      <= a_sh_s;
            b_sh_r      <= b_sh_s;
            sum_r       <= sum_s;
            carry_r     <= carry_s;
            cout_r      <= cout_s;
            cnt_r       <= cnt_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
`ifdef OVERFLOW_DETECT_EN
            ovf_r       <= ovf_s;
`endif
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
`ifdef OVERFLOW_DETECT_EN
    assign bus.ovf       = ovf_r;
`endif

endmodule
